ff_bank: RTL

FF_BANK -- requirements
Module: ff_bank

---
 rtl/ff_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ff_bank.sv
// ff_bank: a bank of WIDTH independent storage bits, all sharing one mode.
//   mode 00 SR, 01 JK, 10 D, 11 T. In SR mode the s=r=1 case follows the
//   CONFLICT parameter (0 hold, 1 set, 2 reset, 3 toggle) and raises a
//   one-cycle conflict pulse plus a sticky error flag.
// Optional feature: define FF_BANK_ERR_CNT_EN to build the saturating
//   conflict event counter; otherwise err_cnt is tied to zero.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         update enable (0 holds all state)
//   mode       operating mode for every bit
//   s, r       per-bit set/J/D/T and reset/K inputs
//   err_clr    clears err_sticky and err_cnt
//   q, qn      registered state and its complement
//   conflict   pulse: previous edge saw s&r overlap in SR mode
//   err_sticky latched conflict flag
//   err_cnt    saturating conflict event count
module ff_bank #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CONFLICT  = 0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn,
    output logic                 conflict,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic             conflict_ev;
    logic [WIDTH-1:0] q_q, q_d;
    logic             conflict_q, conflict_d;
    logic             err_sticky_q, err_sticky_d;

    assign mode_sel    = mode_e'(mode);
    // One event per edge regardless of how many bits overlap.
    assign conflict_ev = en && (mode_sel == MODE_SR) && (|(s & r));

    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (mode_sel)
                MODE_SR: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        unique case ({s[i], r[i]})
                            2'b10:   q_d[i] = 1'b1;
                            2'b01:   q_d[i] = 1'b0;
                            2'b11: begin
                                case (CONFLICT)
                                    1:       q_d[i] = 1'b1;
                                    2:       q_d[i] = 1'b0;
                                    3:       q_d[i] = ~q_q[i];
                                    default: q_d[i] = q_q[i];
                                endcase
                            end
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                MODE_JK: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        unique case ({s[i], r[i]})
                            2'b10:   q_d[i] = 1'b1;
                            2'b01:   q_d[i] = 1'b0;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                MODE_D:  q_d = s;
                MODE_T:  q_d = q_q ^ s;
                default: q_d = q_q;
            endcase
        end
    end

    always_comb begin
        conflict_d = conflict_ev;
        // A new conflict outranks a simultaneous clear.
        if (conflict_ev) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q          <= '0;
            conflict_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            conflict_q   <= conflict_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign q          = q_q;
    assign qn         = ~q_q;
    assign conflict   = conflict_q;
    assign err_sticky = err_sticky_q;

`ifdef FF_BANK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            // Clear and count in the same edge: the new event survives.
            err_cnt_d = conflict_ev ? ERR_CNT_W'(1) : '0;
        end else if (conflict_ev && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
